// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - RV32I opcode and immediate-format codes shared by decode and execute
package imm_decode_stage_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Illegal opcodes report FMT_R so the immediate path yields zero.
    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        fmt_e f;
        f = FMT_R;
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM, FENCE: f = FMT_I;
            STORE:                             f = FMT_S;
            BRANCH:                            f = FMT_B;
            LUI, AUIPC:                        f = FMT_U;
            JAL:                               f = FMT_J;
            default:                           f = FMT_R;
        endcase
        return f;
    endfunction

    function automatic logic opcode_legal(input logic [6:0] opcode);
        logic legal;
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM, FENCE, STORE, BRANCH,
            LUI, AUIPC, JAL, OP: legal = 1'b1;
            default:             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/imm_decode_stage_assemble.sv
// rtl/imm_decode_stage_assemble.sv - combinational RV32I immediate gather and sign extension
module imm_assemble
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    fmt_e        fmt_sel;
    logic [31:0] imm32;

    always_comb begin
        fmt_sel = opcode_fmt(instr[6:0]);
        illegal = !opcode_legal(instr[6:0]);
        imm32   = 32'd0;
        case (fmt_sel)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'd0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign fmt = fmt_sel;
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate decode stage with 2-entry skid and illegal counter
module imm_decode_stage
    import imm_decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_ill;

    logic             out_valid;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_ill;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_ill;

    logic             ready_q;
    logic [CNT_W-1:0] cnt;

    logic             in_fire;
    logic             out_fire;

    imm_assemble #(.XLEN(XLEN)) u_assemble (
        .instr   (i_instr),
        .fmt     (dec_fmt),
        .illegal (dec_ill),
        .imm     (dec_imm)
    );

    assign in_fire  = i_valid && ready_q;
    assign out_fire = out_valid && i_ready;

    // ready_q mirrors "skid entry will be empty", so an accept never lands on a full skid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_fmt    <= 3'd0;
            out_ill    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= 3'd0;
            skid_ill   <= 1'b0;
            ready_q    <= 1'b0;
            cnt        <= '0;
        end else if (i_flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            if (in_fire && dec_ill && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (skid_valid) begin
                if (out_fire) begin
                    out_imm    <= skid_imm;
                    out_fmt    <= skid_fmt;
                    out_ill    <= skid_ill;
                    skid_valid <= 1'b0;
                    ready_q    <= 1'b1;
                end
            end else if (out_valid && !i_ready) begin
                if (in_fire) begin
                    skid_imm   <= dec_imm;
                    skid_fmt   <= dec_fmt;
                    skid_ill   <= dec_ill;
                    skid_valid <= 1'b1;
                    ready_q    <= 1'b0;
                end
            end else begin
                // Output empty or draining this cycle: a new word bypasses the skid.
                if (in_fire) begin
                    out_imm   <= dec_imm;
                    out_fmt   <= dec_fmt;
                    out_ill   <= dec_ill;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
                ready_q <= 1'b1;
            end
        end
    end

    assign o_ready       = ready_q;
    assign o_valid       = out_valid;
    assign o_imm         = out_imm;
    assign o_fmt         = out_fmt;
    assign o_illegal     = out_ill;
    assign o_illegal_cnt = cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - randomized scoreboard bench for imm_decode_stage
module tb_imm_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_imm;
    logic [2:0]  o_fmt;
    logic        o_illegal;
    logic [15:0] o_illegal_cnt;

    logic        o_ready2;
    logic        o_valid2;
    logic [31:0] o_imm2;
    logic [2:0]  o_fmt2;
    logic        o_illegal2;
    logic [1:0]  o_illegal_cnt2;

    always #5 i_clk = ~i_clk;

    imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
        .o_valid(o_valid), .i_ready(i_ready), .o_imm(o_imm),
        .o_fmt(o_fmt), .o_illegal(o_illegal), .o_illegal_cnt(o_illegal_cnt)
    );

    imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready2), .i_instr(i_instr),
        .o_valid(o_valid2), .i_ready(i_ready), .o_imm(o_imm2),
        .o_fmt(o_fmt2), .o_illegal(o_illegal2), .o_illegal_cnt(o_illegal_cnt2)
    );

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   m_ready;
    int   m_cnt;
    int   m_cnt2;
    bit   last_in;
    int   n_out;
    int   checks;
    int   failures;

    logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int   v;
        e.imm = 32'd0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        v = 0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
                e.fmt = 3'd1;
                v = $signed(w) >>> 20;
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = int'(w & 32'hFFFF_F000);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            end
            7'h33: e.fmt = 3'd0;
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = ops[k];
        return w;
    endfunction

    task automatic step();
        bit   in_f;
        bit   out_f;
        exp_t e;
        @(negedge i_clk);
        check_eq("ready", 32'(o_ready), 32'(m_ready));
        check_eq("valid", 32'(o_valid), 32'(q.size() != 0));
        if (q.size() != 0 && o_valid) begin
            check_eq("imm", o_imm, q[0].imm);
            check_eq("fmt", 32'(o_fmt), 32'(q[0].fmt));
            check_eq("illegal", 32'(o_illegal), 32'(q[0].ill));
        end
        check_eq("cnt", 32'(o_illegal_cnt), m_cnt);
        check_eq("cnt2", 32'(o_illegal_cnt2), m_cnt2);
        in_f  = i_valid && m_ready && !i_flush && i_rst_n;
        out_f = (q.size() != 0) && i_ready;
        @(posedge i_clk);
        if (!i_rst_n) begin
            q.delete();
            m_ready = 1'b0;
            m_cnt   = 0;
            m_cnt2  = 0;
        end else if (i_flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            if (out_f) begin
                void'(q.pop_front());
                n_out++;
            end
            if (in_f) begin
                e = ref_decode(i_instr);
                q.push_back(e);
                if (e.ill) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
            m_ready = (q.size() < 2);
        end
        last_in = in_f;
        #1;
    endtask

    logic [31:0] vw [5] = '{32'hFF60_0093, 32'hFE20_AE23, 32'hFE00_0CE3, 32'h8000_00B7, 32'h0010_006F};
    logic [31:0] vi [5] = '{32'hFFFF_FFF6, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h8000_0000, 32'h0000_0800};
    logic [2:0]  vf [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    initial begin
        logic [31:0] words [4];
        int          idx;
        int          saved;
        checks = 0; failures = 0;
        m_ready = 1'b0; m_cnt = 0; m_cnt2 = 0; n_out = 0; last_in = 1'b0;
        i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_instr = 32'd0;
        step();
        step();
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_imm", o_imm, 32'd0);
        check_eq("rst_fmt", 32'(o_fmt), 32'd0);
        check_eq("rst_illegal", 32'(o_illegal), 32'd0);
        check_eq("rst_cnt", 32'(o_illegal_cnt), 32'd0);
        check_eq("rst_ready", 32'(o_ready), 32'd0);
        i_rst_n = 1'b1;
        step();
        check_eq("ready_after_rst", 32'(o_ready), 32'd1);

        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1; i_instr = vw[k]; i_ready = 1'b1;
            step();
            check_eq("vec_valid", 32'(o_valid), 32'd1);
            check_eq("vec_imm", o_imm, vi[k]);
            check_eq("vec_fmt", 32'(o_fmt), 32'(vf[k]));
            i_valid = 1'b0;
            step();
        end

        i_valid = 1'b1; i_instr = 32'hFFFF_FFFF; i_ready = 1'b1;
        step();
        check_eq("ill_flag", 32'(o_illegal), 32'd1);
        check_eq("ill_imm", o_imm, 32'd0);
        check_eq("ill_cnt1", 32'(o_illegal_cnt), 32'd1);
        for (int k = 0; k < 4; k++) step();
        i_valid = 1'b0;
        step();
        check_eq("ill_cnt5", 32'(o_illegal_cnt), 32'd5);
        check_eq("ill_cnt_sat", 32'(o_illegal_cnt2), 32'd3);

        for (int k = 0; k < 4; k++) begin
            words[k] = gen_instr();
            words[k][6:0] = ops[k];
        end
        idx = 0; n_out = 0;
        for (int c = 0; c < 30 && n_out < 4; c++) begin
            i_ready = (c >= 3);
            i_valid = (idx < 4);
            i_instr = (idx < 4) ? words[idx] : 32'd0;
            step();
            if (last_in) idx++;
            if (c == 2) begin
                check_eq("stall_ready", 32'(o_ready), 32'd0);
                check_eq("stall_accepted", idx, 2);
            end
        end
        i_valid = 1'b0;
        check_eq("stream_in", idx, 4);
        check_eq("stream_out", n_out, 4);
        step();

        i_ready = 1'b0; i_valid = 1'b1;
        i_instr = gen_instr(); step();
        i_instr = gen_instr(); step();
        saved = m_cnt;
        i_instr = 32'hFFFF_FFFF; i_flush = 1'b1;
        step();
        check_eq("flush_valid", 32'(o_valid), 32'd0);
        check_eq("flush_cnt", 32'(o_illegal_cnt), saved);
        check_eq("flush_ready", 32'(o_ready), 32'd1);
        i_flush = 1'b0; i_valid = 1'b0;
        step();

        i_ready = 1'b0; i_valid = 1'b1;
        i_instr = 32'hFFFF_FFFF; step();
        i_instr = gen_instr(); step();
        i_rst_n = 1'b0;
        step();
        check_eq("midrst_valid", 32'(o_valid), 32'd0);
        check_eq("midrst_imm", o_imm, 32'd0);
        check_eq("midrst_fmt", 32'(o_fmt), 32'd0);
        check_eq("midrst_illegal", 32'(o_illegal), 32'd0);
        check_eq("midrst_cnt", 32'(o_illegal_cnt), 32'd0);
        check_eq("midrst_ready", 32'(o_ready), 32'd0);
        i_rst_n = 1'b1; i_valid = 1'b0;
        step();

        for (int c = 0; c < 600; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 39) == 0);
            i_instr = gen_instr();
            step();
        end
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        for (int c = 0; c < 3; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
